fetch_queue: RTL and testbench

- Instruction-fetch front end sitting directly upstream of the pipelined datapath's fetch pipe register; sources InstrF/PCF/PCPlus4F.
- Owns the architectural fetch PC and issues in-order requests to instruction memory over a valid/ready request channel and a fixed-order response channel.
- Buffers returned instructions in a small FIFO, absorbs StallF, and flushes/redirects on PCSrcE.

---
 rtl/fetch_queue.sv | 166 ++++++++++++++++
 tb/tb_fetch_queue.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Owns the architectural fetch PC,
// issues in-order requests to instruction memory under a credit limit, buffers
// the returned words in a DEPTH-entry FIFO and presents the head entry to the
// fetch pipe register. A redirect flushes the FIFO and drops every response
// still in flight.
module fetch_queue #(
   parameter int                  BITWIDTH = 32,
   parameter int                  DEPTH    = 4,
   parameter logic [BITWIDTH-1:0] RESET_PC = '0,
   parameter logic [BITWIDTH-1:0] NOP      = BITWIDTH'(32'h0000_0013),
   localparam int                 CW       = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                stall,
   input  logic                redirect,
   input  logic [BITWIDTH-1:0] redirect_pc,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [BITWIDTH-1:0] imem_req_addr,
   input  logic                imem_resp_valid,
   input  logic [BITWIDTH-1:0] imem_resp_data,
   output logic [BITWIDTH-1:0] InstrF,
   output logic [BITWIDTH-1:0] PCF,
   output logic [BITWIDTH-1:0] PCPlus4F,
   output logic                instr_valid,
   output logic [CW-1:0]       occupancy
);

   localparam int                  PW        = $clog2(DEPTH);
   localparam logic [CW:0]         DEPTH_LIM = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0]       DEPTH_CNT = CW'(DEPTH);
   localparam logic [BITWIDTH-1:0] PC_STEP   = BITWIDTH'(4);

   // Architectural and bookkeeping state
   logic [BITWIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [BITWIDTH-1:0] resp_pc_q, resp_pc_d;
   logic [BITWIDTH-1:0] last_pc_q, last_pc_d;
   logic [CW-1:0]       count_q, count_d;
   logic [CW-1:0]       outstanding_q, outstanding_d;
   logic [CW-1:0]       discard_q, discard_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;

   // FIFO storage: instruction word and the PC it was fetched from
   logic [BITWIDTH-1:0] instr_mem_q [DEPTH];
   logic [BITWIDTH-1:0] pc_mem_q    [DEPTH];

   logic credit_ok;
   logic req_accept;
   logic resp_drop;
   logic push;
   logic pop;
   logic head_valid;

   // Credits cover both buffered entries and requests still in flight, so a
   // response can never find the FIFO full.
   assign credit_ok      = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_LIM;
   assign imem_req_valid = ~rst & en & ~redirect & credit_ok;
   assign imem_req_addr  = fetch_pc_q;
   assign req_accept     = imem_req_valid & imem_req_ready;

   // Responses cannot be back-pressured: they are captured regardless of en.
   assign resp_drop  = imem_resp_valid & (discard_q != '0);
   assign push       = imem_resp_valid & (discard_q == '0) & ~redirect;
   assign head_valid = (count_q != '0);
   assign pop        = head_valid & en & ~stall & ~redirect;

   // Head of the FIFO drives the fetch stage; an empty queue shows a bubble
   // while PCF keeps the last PC handed downstream.
   assign instr_valid = head_valid;
   assign InstrF      = head_valid ? instr_mem_q[rd_ptr_q] : NOP;
   assign PCF         = head_valid ? pc_mem_q[rd_ptr_q] : last_pc_q;
   assign PCPlus4F    = PCF + PC_STEP;
   assign occupancy   = count_q;

   // Next-state for PCs, counters and pointers; redirect overrides everything
   always_comb begin
      // NOTE: every _d takes its _q value first so no path through this block infers a latch.
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      last_pc_d     = last_pc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;

      if (redirect) begin
         fetch_pc_d    = redirect_pc;
         resp_pc_d     = redirect_pc;
         count_d       = '0;
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
         // No request is accepted in a redirect cycle, so whatever remains in
         // flight after this edge belongs to the old path and is dropped.
         outstanding_d = outstanding_q - CW'(imem_resp_valid);
         discard_d     = outstanding_q - CW'(imem_resp_valid);
      end else begin
         if (req_accept) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end
         outstanding_d = outstanding_q + CW'(req_accept) - CW'(imem_resp_valid);
         if (resp_drop) begin
            discard_d = discard_q - CW'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + PC_STEP;
            wr_ptr_d  = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end

      if (pop) begin
         last_pc_d = pc_mem_q[rd_ptr_q];
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         last_pc_q     <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         last_pc_q     <= last_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
      end
   end

   // FIFO write port
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; an entry is only read after count_q marks it written.
      if (push) begin
         instr_mem_q[wr_ptr_q] <= imem_resp_data;
         pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      end
   end

`ifndef SYNTHESIS
   // A response into a full FIFO means the credit accounting is broken
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && (count_q == DEPTH_CNT)))
            else $error("fetch_queue: response pushed into a full FIFO");
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed stimulus against a queue-based
// reference model of the fetch front end, plus an in-order memory model.
module tb_fetch_queue;

   localparam int          BW       = 32;
   localparam int          DEPTH    = 4;
   localparam int          CW       = $clog2(DEPTH + 1);
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          stall;
   logic          redirect;
   logic [BW-1:0] redirect_pc;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [BW-1:0] imem_req_addr;
   logic          imem_resp_valid;
   logic [BW-1:0] imem_resp_data;
   logic [BW-1:0] InstrF;
   logic [BW-1:0] PCF;
   logic [BW-1:0] PCPlus4F;
   logic          instr_valid;
   logic [CW-1:0] occupancy;

   always #5 clk = ~clk;

   fetch_queue #(
      .BITWIDTH(BW),
      .DEPTH   (DEPTH),
      .RESET_PC(RESET_PC),
      .NOP     (NOP)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .InstrF         (InstrF),
      .PCF            (PCF),
      .PCPlus4F       (PCPlus4F),
      .instr_valid    (instr_valid),
      .occupancy      (occupancy)
   );

   // Reference model: requests in flight tagged stale/fresh, buffered entries
   typedef struct { logic [31:0] pc; bit stale; }         infl_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   typedef struct { int due; logic [31:0] addr; }          mreq_t;

   infl_t       infl_q[$];
   ent_t        fifo_q[$];
   mreq_t       mem_q[$];
   logic [31:0] m_fetch_pc;
   logic [31:0] m_last_pc;

   int          vectors;
   int          miscompares;
   int          cyc;
   int          lat;
   logic [31:0] key;

   // Stimulus for the next cycle
   bit          d_en, d_stall, d_redirect, d_ready;
   logic [31:0] d_rpc;

   // DUT outputs sampled in the most recent cycle
   logic        s_valid, s_req_valid;
   logic [31:0] s_instr, s_pc, s_plus4, s_addr;
   int          s_occ;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      infl_q.delete();
      fifo_q.delete();
      mem_q.delete();
      m_fetch_pc = RESET_PC;
      m_last_pc  = 32'h0;
      cyc        = 0;
   endtask

   task automatic drive(input bit e, input bit s, input bit r, input bit rd, input logic [31:0] pc);
      d_en       = e;
      d_stall    = s;
      d_redirect = r;
      d_ready    = rd;
      d_rpc      = pc;
   endtask

   // Assert reset between edges, check reset outputs at once, then release.
   task automatic do_reset();
      rst             = 1'b1;
      en              = 1'b1;
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_pc     = '0;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_instr_valid", 32'(instr_valid), 32'h0);
      check("rst_InstrF", InstrF, NOP);
      check("rst_PCF", PCF, 32'h0);
      check("rst_PCPlus4F", PCPlus4F, 32'h4);
      check("rst_occupancy", 32'(occupancy), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // One clock cycle: apply stimulus, compare every output, advance the model.
   task automatic step();
      bit          m_req, m_head, m_pop, rv;
      logic [31:0] rdat, exp_pc;
      infl_t       f;
      en             = d_en;
      stall          = d_stall;
      redirect       = d_redirect;
      redirect_pc    = d_rpc;
      imem_req_ready = d_ready;
      rv   = 1'b0;
      rdat = '0;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
         rv   = 1'b1;
         rdat = mem_q[0].addr ^ key;
         void'(mem_q.pop_front());
      end
      imem_resp_valid = rv;
      imem_resp_data  = rdat;
      #2;

      m_req  = d_en && !d_redirect && (fifo_q.size() + infl_q.size() < DEPTH);
      m_head = fifo_q.size() > 0;
      exp_pc = m_head ? fifo_q[0].pc : m_last_pc;
      check("req_valid", 32'(imem_req_valid), 32'(m_req));
      if (m_req) check("req_addr", imem_req_addr, m_fetch_pc);
      check("instr_valid", 32'(instr_valid), 32'(m_head));
      check("occupancy", 32'(occupancy), 32'(fifo_q.size()));
      check("InstrF", InstrF, m_head ? fifo_q[0].instr : NOP);
      check("PCF", PCF, exp_pc);
      check("PCPlus4F", PCPlus4F, exp_pc + 32'd4);

      s_valid     = instr_valid;
      s_req_valid = imem_req_valid;
      s_instr     = InstrF;
      s_pc        = PCF;
      s_plus4     = PCPlus4F;
      s_addr      = imem_req_addr;
      s_occ       = int'(occupancy);

      m_pop = m_head && d_en && !d_stall && !d_redirect;
      if (m_pop) begin
         m_last_pc = fifo_q[0].pc;
         void'(fifo_q.pop_front());
      end
      if (rv && infl_q.size() > 0) begin
         f = infl_q.pop_front();
         if (!f.stale && !d_redirect) fifo_q.push_back('{f.pc, rdat});
      end
      if (m_req && d_ready) begin
         infl_q.push_back('{m_fetch_pc, 1'b0});
         mem_q.push_back('{cyc + lat, m_fetch_pc});
         m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (d_redirect) begin
         fifo_q.delete();
         foreach (infl_q[i]) infl_q[i].stale = 1'b1;
         m_fetch_pc = d_rpc;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic random_drive(input int redir_mod);
      logic [29:0] word;
      word = ($urandom_range(3) == 0) ? 30'h3FFF_FFFC : 30'($urandom);
      drive($urandom_range(7) != 0, $urandom_range(2) == 0,
            $urandom_range(redir_mod - 1) == 0, $urandom_range(3) != 0, {word, 2'b00});
   endtask

   initial begin
      int          n;
      logic [31:0] seen [5];
      vectors     = 0;
      miscompares = 0;
      lat         = 1;
      key         = 32'h0;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      model_reset();

      // Cold start, 1-cycle memory returning the address as data
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 8; i++) begin
         step();
         if (i < 4) check("t1_req_addr", s_addr, 32'(i * 4));
         if (i == 1) check("t1_not_yet_valid", 32'(s_valid), 32'h0);
         if (i == 2) begin
            check("t1_first_valid", 32'(s_valid), 32'h1);
            check("t1_first_PCF", s_pc, 32'h0);
            check("t1_first_PCPlus4F", s_plus4, 32'h4);
            check("t1_first_InstrF", s_instr, 32'h0);
         end
      end

      // Stall fills the queue; release drains it in order
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
      repeat (10) step();
      check("t2_full_occ", 32'(s_occ), 32'(DEPTH));
      check("t2_full_no_req", 32'(s_req_valid), 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (s_valid && n < 5) begin
            seen[n] = s_pc;
            n++;
         end
      end
      check("t2_drained", 32'(n), 32'd5);
      for (int i = 0; i < 5; i++) check("t2_pc_seq", seen[i], 32'(i * 4));

      // Redirect with three requests in flight on a 3-cycle memory
      do_reset();
      lat = 3;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      repeat (3) step();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      step();
      check("t3_occ_after_redirect", 32'(s_occ), 32'h0);
      n = 0;
      for (int i = 0; i < 30 && n == 0; i++) begin
         step();
         if (s_valid) begin
            n = 1;
            check("t3_first_PCF", s_pc, 32'h100);
            check("t3_first_InstrF", s_instr, 32'h100);
         end
      end
      check("t3_valid_seen", 32'(n), 32'h1);

      // Memory not ready: address holds, queue drains to a bubble
      do_reset();
      lat = 1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      repeat (2) step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t5_addr_stable", s_addr, 32'h8);
         check("t5_req_held", 32'(s_req_valid), 32'h1);
      end
      check("t5_bubble_valid", 32'(s_valid), 32'h0);
      check("t5_bubble_InstrF", s_instr, NOP);

      // Randomized phases over several memory latencies and redirect rates
      for (int p = 0; p < 4; p++) begin
         do_reset();
         lat = 1 + p;
         key = $urandom;
         for (int i = 0; i < 500; i++) begin
            random_drive((p == 3) ? 3 : 12);
            step();
         end
      end

      // Asynchronous reset in the middle of traffic, then refetch from RESET_PC
      do_reset();
      lat = 2;
      key = $urandom;
      for (int i = 0; i < 40; i++) begin
         random_drive(12);
         d_stall = (i > 25);
         step();
      end
      #2;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      step();
      check("t6_refetch_valid", 32'(s_req_valid), 32'h1);
      check("t6_refetch_addr", s_addr, RESET_PC);
      repeat (10) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
